// File: rtl/message_printer_if.sv
// Signal bundle between the message printer and its UART rx/tx pair and message ROM.
// master = printer side, slave = environment (UART, ROM, testbench).
interface message_printer_if #(
    parameter int ADDR_W = 4
) ();
    logic [7:0]        rx_data;
    logic              new_rx_data;
    logic              tx_busy;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic              active;
    logic              done;

    modport master (
        input  rx_data, new_rx_data, tx_busy, rom_data,
        output rom_addr, tx_data, new_tx_data, active, done
    );

    modport slave (
        output rx_data, new_rx_data, tx_busy, rom_data,
        input  rom_addr, tx_data, new_tx_data, active, done
    );
endinterface

// File: rtl/message_printer.sv
// Streams MSG_LEN bytes from a registered-output ROM into a UART transmitter,
// one run per received TRIGGER_CHAR.
module message_printer #(
    parameter int          MSG_LEN      = 16,
    parameter int          ADDR_W       = 4,
    parameter logic [7:0]  TRIGGER_CHAR = 8'h68
) (
    input logic             clk,
    input logic             rst_n,
    message_printer_if.master bus
);

    if (MSG_LEN < 1 || MSG_LEN > (1 << ADDR_W)) begin : g_bad_len
        $error("message_printer: MSG_LEN must be in 1..2**ADDR_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              new_tx_q, new_tx_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tx_data_q <= '0;
            new_tx_q  <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_data_d = tx_data_q;
        new_tx_d  = 1'b0;
        active_d  = active_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                addr_d   = '0;
                active_d = 1'b0;
                if (bus.new_rx_data && (bus.rx_data == TRIGGER_CHAR)) begin
                    state_d  = FETCH;
                    active_d = 1'b1;
                end
            end
            // One-cycle slot that covers the ROM's registered read latency.
            FETCH: begin
                state_d = SEND;
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_data_d = bus.rom_data;
                    new_tx_d  = 1'b1;
                    state_d   = HOLD;
                end
            end
            // Guard cycle: gives the transmitter time to raise tx_busy.
            HOLD: begin
                if (addr_q == LAST_ADDR) begin
                    state_d  = IDLE;
                    addr_d   = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rom_addr    = addr_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.new_tx_data = new_tx_q;
    assign bus.active      = active_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_message_printer.sv
// Bench for message_printer: ROM and transmitter models, table-driven trigger
// vectors, back-pressure/retrigger/reset sequences and a MSG_LEN=1 instance.
module tb_message_printer;

    localparam int MSG_LEN = 16;
    localparam int HIST    = 20000;

    logic clk;
    logic rst_n;

    message_printer_if #(.ADDR_W(4)) ifc ();
    message_printer_if #(.ADDR_W(4)) ifc1 ();

    message_printer #(.MSG_LEN(MSG_LEN), .ADDR_W(4), .TRIGGER_CHAR(8'h68)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    message_printer #(.MSG_LEN(1), .ADDR_W(4), .TRIGGER_CHAR(8'h68)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.master)
    );

    logic [7:0] msg [16];
    initial begin
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h0A, 8'h0D,
                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A, 8'h0D};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Message ROM models: data registered one edge after the address.
    always @(posedge clk) ifc.rom_data  <= msg[ifc.rom_addr];
    always @(posedge clk) ifc1.rom_data <= msg[ifc1.rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Observation log of the main DUT.
    bit busy_hist [HIST];
    bit act_hist  [HIST];
    int pulse_cyc [$];
    int pulse_byte[$];
    int done_cyc  [$];
    bit prev_pulse = 1'b0;
    bit prev_done  = 1'b0;
    int mode = 0;   // 0: never busy, 1: busy 10 cycles after each byte, 2: random

    always @(negedge clk) begin
        if (cyc < HIST) begin
            busy_hist[cyc] = ifc.tx_busy;
            act_hist[cyc]  = ifc.active;
        end
        if (ifc.new_tx_data) begin
            check("tx_single_cycle", int'(prev_pulse), 0);
            if (cyc > 0) check("tx_after_busy_low", int'(busy_hist[cyc-1]), 0);
            if (mode != 2) check("tx_while_busy", int'(ifc.tx_busy), 0);
            pulse_cyc.push_back(cyc);
            pulse_byte.push_back(int'(ifc.tx_data));
        end
        if (ifc.done) begin
            check("done_single_cycle", int'(prev_done), 0);
            done_cyc.push_back(cyc);
        end
        prev_pulse = ifc.new_tx_data;
        prev_done  = ifc.done;
    end

    // Transmitter model for the main DUT.
    initial begin
        int  bcnt;
        bit  p;
        bcnt = 0;
        ifc.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            p = ifc.new_tx_data;
            @(posedge clk);
            #1;
            case (mode)
                1: begin
                    if (p) bcnt = 10;
                    ifc.tx_busy = (bcnt != 0);
                    if (bcnt != 0) bcnt--;
                end
                2: ifc.tx_busy = ($urandom_range(0, 1) == 1);
                default: ifc.tx_busy = 1'b0;
            endcase
        end
    end

    task automatic pulse_rx(input logic [7:0] b, output int t);
        ifc.rx_data     = b;
        ifc.new_rx_data = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        ifc.new_rx_data = 1'b0;
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_byte.delete();
        done_cyc.delete();
    endtask

    task automatic do_trigger(input logic [7:0] b, output int t);
        @(posedge clk);
        #1;
        clear_log();
        pulse_rx(b, t);
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ifc.done) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    // Reference: each byte goes out on the first cycle after the SEND slot
    // (>= previous pulse + 2) in which tx_busy was seen low.
    task automatic check_run(input int t);
        int exp_c [$];
        int p, c, n, mism;
        p = t;
        for (int k = 0; k < MSG_LEN; k++) begin
            c = p + 3;
            while (c < HIST && busy_hist[c-1]) c++;
            exp_c.push_back(c);
            p = c;
        end
        check("byte_count", pulse_cyc.size(), MSG_LEN);
        n = (pulse_cyc.size() < MSG_LEN) ? pulse_cyc.size() : MSG_LEN;
        for (int k = 0; k < n; k++) begin
            check($sformatf("byte%0d_value", k), pulse_byte[k], int'(msg[k]));
            check($sformatf("byte%0d_cycle", k), pulse_cyc[k], exp_c[k]);
        end
        check("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check("done_cycle", done_cyc[0], p + 1);
        mism = 0;
        for (int cc = t; cc <= p + 1 && cc < HIST; cc++)
            if (act_hist[cc] != ((cc > t) && (cc <= p))) mism++;
        check("active_window", mism, 0);
    endtask

    typedef struct {
        logic [7:0] rx;
        bit         strobe;
        bit         exp_start;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int t, t2, nb, c, anyact;

        tbl[0] = '{rx: 8'h41, strobe: 1'b1, exp_start: 1'b0};
        tbl[1] = '{rx: 8'h68, strobe: 1'b0, exp_start: 1'b0};
        tbl[2] = '{rx: 8'h48, strobe: 1'b1, exp_start: 1'b0};
        tbl[3] = '{rx: 8'hE8, strobe: 1'b1, exp_start: 1'b0};
        tbl[4] = '{rx: 8'h68, strobe: 1'b1, exp_start: 1'b1};
        tbl[5] = '{rx: 8'h00, strobe: 1'b1, exp_start: 1'b0};
        tbl[6] = '{rx: 8'h69, strobe: 1'b1, exp_start: 1'b0};

        rst_n = 1'b0;
        ifc.rx_data = 8'h00;   ifc.new_rx_data = 1'b0;
        ifc1.rx_data = 8'h00;  ifc1.new_rx_data = 1'b0;  ifc1.tx_busy = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_rom_addr", int'(ifc.rom_addr), 0);
        check("rst_tx_data", int'(ifc.tx_data), 0);
        check("rst_new_tx", int'(ifc.new_tx_data), 0);
        check("rst_active", int'(ifc.active), 0);
        check("rst_done", int'(ifc.done), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Table-driven trigger vectors, transmitter always ready.
        mode = 0;
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            clear_log();
            ifc.rx_data = tbl[i].rx;
            if (tbl[i].strobe) pulse_rx(tbl[i].rx, t);
            else begin
                t = cyc;
                @(posedge clk);
                #1;
            end
            if (tbl[i].exp_start) begin
                wait_done(200);
                #1;
                check_run(t);
                check("addr_back_to_0", int'(ifc.rom_addr), 0);
            end else begin
                repeat (6) @(negedge clk);
                anyact = 0;
                for (int cc = t; cc <= t + 6; cc++) if (act_hist[cc]) anyact++;
                check($sformatf("vec%0d_no_active", i), anyact, 0);
                check($sformatf("vec%0d_no_tx", i), pulse_cyc.size(), 0);
                check($sformatf("vec%0d_no_done", i), done_cyc.size(), 0);
            end
        end

        // Back-pressure with a retrigger at T+10.
        mode = 1;
        do_trigger(8'h68, t);
        while (cyc < t + 10) begin
            @(posedge clk);
            #1;
        end
        pulse_rx(8'h68, t2);
        wait_done(2000);
        #1;
        check_run(t);
        repeat (60) @(negedge clk);
        check("retrig_no_extra_tx", pulse_cyc.size(), MSG_LEN);
        check("retrig_done_once", done_cyc.size(), 1);
        mode = 0;
        repeat (12) @(posedge clk);

        // Asynchronous reset in the middle of a run.
        do_trigger(8'h68, t);
        for (int i = 0; i < 200 && pulse_cyc.size() < 5; i++) @(negedge clk);
        check("five_bytes_before_reset", pulse_cyc.size(), 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rom_addr", int'(ifc.rom_addr), 0);
        check("mid_rst_tx_data", int'(ifc.tx_data), 0);
        check("mid_rst_new_tx", int'(ifc.new_tx_data), 0);
        check("mid_rst_active", int'(ifc.active), 0);
        check("mid_rst_done", int'(ifc.done), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        nb = pulse_cyc.size();
        repeat (30) @(negedge clk);
        check("no_tx_after_reset", pulse_cyc.size(), nb);
        check("idle_after_reset", int'(ifc.active), 0);
        check("no_done_after_reset", done_cyc.size(), 0);
        do_trigger(8'h68, t);
        wait_done(200);
        #1;
        check_run(t);

        // Trigger landing in the done cycle starts a second run.
        repeat (4) @(posedge clk);
        do_trigger(8'h68, t);
        wait_done(200);
        check("done_at_T49", cyc, t + 3 * MSG_LEN + 1);
        pulse_rx(8'h68, t2);
        check_run(t);
        clear_log();
        wait_done(200);
        #1;
        check_run(t2);
        check("second_run_first_at_T52", pulse_cyc.size() > 0 ? pulse_cyc[0] : -1, t + 52);

        // Randomized transmitter back-pressure.
        mode = 2;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            do_trigger(8'h68, t);
            wait_done(3000);
            #1;
            check_run(t);
        end
        mode = 0;
        repeat (5) @(posedge clk);

        // MSG_LEN = 1 instance.
        @(posedge clk);
        #1;
        ifc1.rx_data = 8'h68;
        ifc1.new_rx_data = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        ifc1.new_rx_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c = cyc;
            check("len1_pulse", int'(ifc1.new_tx_data), int'(c == t + 3));
            if (c == t + 3) check("len1_byte", int'(ifc1.tx_data), 8'h48);
            check("len1_done", int'(ifc1.done), int'(c == t + 4));
            check("len1_active", int'(ifc1.active), int'((c > t) && (c <= t + 3)));
            check("len1_addr", int'(ifc1.rom_addr), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
